inst_buffer: RTL



---
 rtl/inst_buffer_pkg.sv | 25 ++
 rtl/inst_buffer.sv | 135 +++++++++++++
 2 files changed

// File: rtl/inst_buffer_pkg.sv
// Shared types and helpers for the instruction buffer between fetch and
// decode/dispatch.
package inst_buffer_pkg;

   // Default buffer depth in entries (power of two)
   localparam int IB_DEPTH = 8;

   typedef logic [31:0] inst_t;
   typedef logic [31:0] addr_t;

   // One buffered instruction: word, its PC and the predicted next PC
   typedef struct packed {
      inst_t inst;
      addr_t pc;
      addr_t npc;
   } ib_entry_t;

   // 32-bit add that sticks at all-ones instead of wrapping
   function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      sat_add32 = sum[32] ? 32'hFFFF_FFFF : sum[31:0];
   endfunction

endpackage

// File: rtl/inst_buffer.sv
// Circular instruction queue between fetch and the per-lane decoders.
// Accepts up to FETCH_WIDTH instructions per cycle, presents the oldest
// DISPATCH_WIDTH entries in program order, flushes in one cycle.
// Optional statistics counters are built when INST_BUF_STATS_EN is defined.
//
// Handshake: fetch may push on any contiguous run of if_valid lanes starting
// at lane 0, at most free_slots of them (extra lanes are dropped). Decode
// consumes id_pop_count entries from lane 0 up, at most popcount(id_valid).
// Both take effect at the posedge; new entries appear on id_* one cycle later.
module inst_buffer
   import inst_buffer_pkg::*;
#(
   parameter int DEPTH          = IB_DEPTH,
   parameter int FETCH_WIDTH    = 2,
   parameter int DISPATCH_WIDTH = 2
) (
   input  logic                                  clock,
   input  logic                                  reset,
   input  logic [FETCH_WIDTH-1:0]                if_valid,
   input  logic [FETCH_WIDTH-1:0][31:0]          if_inst,
   input  logic [FETCH_WIDTH-1:0][31:0]          if_pc,
   input  logic [FETCH_WIDTH-1:0][31:0]          if_npc,
   output logic [$clog2(DEPTH):0]                free_slots,
   output logic [DISPATCH_WIDTH-1:0]             id_valid,
   output ib_entry_t [DISPATCH_WIDTH-1:0]        id_entry,
   input  logic [$clog2(DISPATCH_WIDTH):0]       id_pop_count,
   input  logic                                  flush
`ifdef INST_BUF_STATS_EN
   ,
   output logic [31:0]                           full_cycles,
   output logic [31:0]                           flushed_insts,
   output logic [31:0]                           dropped_pushes
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   ib_entry_t           mem [DEPTH];
   logic [PW-1:0]       head, tail;
   logic [CW-1:0]       count;

   logic [CW-1:0]       free;
   logic [CW-1:0]       push_req, n_push;
   logic [CW-1:0]       pop_req, n_pop;

   // Number of set request bits in an unbroken run from lane 0
   function automatic logic [CW-1:0] lead_ones(input logic [FETCH_WIDTH-1:0] v);
      logic run;
      lead_ones = '0;
      run       = 1'b1;
      for (int k = 0; k < FETCH_WIDTH; k++) begin
         run = run & v[k];
         if (run) lead_ones = lead_ones + CW'(1);
      end
   endfunction

   // Clamp push to space at start of cycle and pop to current occupancy
   always_comb begin
      free     = CW'(DEPTH) - count;
      push_req = lead_ones(if_valid);
      n_push   = (push_req > free) ? free : push_req;
      pop_req  = CW'(id_pop_count);
      n_pop    = (pop_req > count) ? count : pop_req;
   end

   // Pointer and occupancy registers; flush wins over push and pop
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + PW'(n_pop);
         tail  <= tail + PW'(n_push);
         count <= count + n_push - n_pop;
      end
   end

   // Storage writes for accepted lanes; the array itself is never reset
   always_ff @(posedge clock) begin
      for (int k = 0; k < FETCH_WIDTH; k++) begin
         if (!flush && (CW'(k) < n_push)) begin
            mem[tail + PW'(k)] <= '{inst: if_inst[k], pc: if_pc[k], npc: if_npc[k]};
         end
      end
   end

   // Head window and free space, driven only from registered state
   always_comb begin
      free_slots = free;
      for (int i = 0; i < DISPATCH_WIDTH; i++) begin
         id_valid[i] = (count > CW'(i));
         id_entry[i] = mem[head + PW'(i)];
      end
   end

`ifdef INST_BUF_STATS_EN
   // Saturating usage counters
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         full_cycles    <= '0;
         flushed_insts  <= '0;
         dropped_pushes <= '0;
      end else begin
         if ((count == CW'(DEPTH)) && if_valid[0])
            full_cycles <= sat_add32(full_cycles, 32'd1);
         if (flush)
            flushed_insts <= sat_add32(flushed_insts, 32'(count));
         else
            dropped_pushes <= sat_add32(dropped_pushes, 32'(push_req - n_push));
      end
   end
`endif

`ifndef SYNTHESIS
   logic [CW-1:0] n_valid;
   assign n_valid = (count < CW'(DISPATCH_WIDTH)) ? count : CW'(DISPATCH_WIDTH);

   // Protocol checks on the consumer and producer sides
   always @(posedge clock) begin
      if (reset) begin
         assert (pop_req <= n_valid)
            else $error("inst_buffer: id_pop_count %0d exceeds valid entries %0d", pop_req, n_valid);
         if (!flush && (push_req > free))
            $warning("inst_buffer: push of %0d lanes exceeds free_slots %0d, clamped", push_req, free);
      end
   end
`endif

endmodule
